// File: rtl/mm_seq_pkg.sv
// Shared types and sizing helpers for the sequenced multi-matmul wrapper.
package mm_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_CAPTURE,
    S_OUT
  } state_t;

  function automatic int k_beats(input int inner_dimension, input int block_size);
    return inner_dimension / block_size;
  endfunction

  // Bits needed to hold a count of 0..max_count-1 (never less than one).
  function automatic int cnt_w(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/multi_matmul.sv
// One matmul lane: per-chunk products of each west row with each north column, accumulated
// over the enabled beats. Result element e = (col*NUM_CORES_A + row)*CHUNK_SIZE + k.
module multi_matmul
  import mm_seq_pkg::*;
#(
  parameter int WIDTH_A         = 16,
  parameter int FRAC_WIDTH_A    = 8,
  parameter int WIDTH_B         = 16,
  parameter int FRAC_WIDTH_B    = 8,
  parameter int WIDTH_OUT       = 16,
  parameter int FRAC_WIDTH_OUT  = 8,
  parameter int BLOCK_SIZE      = 2,
  parameter int CHUNK_SIZE      = 4,
  parameter int NUM_CORES_A     = 4,
  parameter int NUM_CORES_B     = 1,
  parameter int TOTAL_MODULES   = 2,
  parameter int INNER_DIMENSION = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reset_acc,
  input  logic en,
  input  logic [WIDTH_A*CHUNK_SIZE*NUM_CORES_A-1:0] input_w,
  input  logic [WIDTH_B*CHUNK_SIZE*NUM_CORES_B*TOTAL_MODULES-1:0] input_n,
  output logic [WIDTH_OUT*CHUNK_SIZE*NUM_CORES_A*NUM_CORES_B*TOTAL_MODULES-1:0] out,
  output logic acc_done
);

  localparam int NC = NUM_CORES_B * TOTAL_MODULES;
  localparam int NE = NC * NUM_CORES_A * CHUNK_SIZE;
  localparam int K  = k_beats(INNER_DIMENSION, BLOCK_SIZE);
  localparam int PW = WIDTH_A + WIDTH_B;
  localparam int AW = PW + $clog2(K + 1) + 1;
  localparam int SH = FRAC_WIDTH_A + FRAC_WIDTH_B - FRAC_WIDTH_OUT;
  localparam int CW = cnt_w(K + 2);
  // One extra enable past the last beat flushes the product register into the accumulator.
  localparam logic [CW-1:0] DONE_CNT = CW'(K + 1);

  logic [PW-1:0] prod_d [NE];
  logic [PW-1:0] prod_q [NE];
  logic [AW-1:0] acc_q  [NE];
  logic          prod_v;
  logic [CW-1:0] en_cnt;

  logic [WIDTH_A-1:0] wv;
  logic [WIDTH_B-1:0] nv;
  logic signed [PW-1:0] wx;
  logic signed [PW-1:0] nx;

  always_comb begin
    prod_d = '{default: '0};
    wv = '0;
    nv = '0;
    wx = '0;
    nx = '0;
    for (int m = 0; m < NC; m++) begin
      for (int a = 0; a < NUM_CORES_A; a++) begin
        for (int k = 0; k < CHUNK_SIZE; k++) begin
          wv = input_w[(a*CHUNK_SIZE + k)*WIDTH_A +: WIDTH_A];
          nv = input_n[(m*CHUNK_SIZE + k)*WIDTH_B +: WIDTH_B];
          wx = {{WIDTH_B{wv[WIDTH_A-1]}}, wv};
          nx = {{WIDTH_A{nv[WIDTH_B-1]}}, nv};
          prod_d[(m*NUM_CORES_A + a)*CHUNK_SIZE + k] = wx * nx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || reset_acc) begin
      prod_v <= 1'b0;
      en_cnt <= '0;
      for (int e = 0; e < NE; e++) begin
        prod_q[e] <= '0;
        acc_q[e]  <= '0;
      end
    end else begin
      prod_v <= en;
      if (en) begin
        for (int e = 0; e < NE; e++) prod_q[e] <= prod_d[e];
        if (en_cnt != DONE_CNT) en_cnt <= en_cnt + 1'b1;
      end
      if (prod_v) begin
        for (int e = 0; e < NE; e++)
          acc_q[e] <= acc_q[e] + {{(AW-PW){prod_q[e][PW-1]}}, prod_q[e]};
      end
    end
  end

  assign acc_done = (en_cnt == DONE_CNT);

  for (genvar e = 0; e < NE; e++) begin : g_out
    assign out[e*WIDTH_OUT +: WIDTH_OUT] = acc_q[e][SH +: WIDTH_OUT];
  end

endmodule

// File: rtl/multi_matmul_seq_wrapper_fsm.sv
// Job sequencer: start/done control, input beat and drain counters, and both handshakes.
// Handshake: a beat moves when in_valid && in_ready, a result when out_valid && out_ready.
module mm_seq_fsm
  import mm_seq_pkg::*;
#(
  parameter int K_BEATS   = 32,
  parameter int DRAIN_MAX = 256,
  parameter int LANES     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LANES-1:0] lane_mask,
  input  logic             in_valid,
  input  logic             all_done,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [LANES-1:0] mask_q,
  output logic             en_raw,
  output logic             reset_acc,
  output logic             capture,
  output logic             zero_inputs,
  output state_t           state_dbg
);

  localparam int BW = cnt_w(K_BEATS);
  localparam int DW = cnt_w(DRAIN_MAX);
  localparam logic [BW-1:0] BEAT_LAST  = BW'(K_BEATS - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);

  state_t        state;
  logic [BW-1:0] beat_cnt;
  logic [DW-1:0] drain_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      mask_q    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mask_q  <= lane_mask;
            timeout <= 1'b0;
            if (lane_mask == '0) begin
              done <= 1'b1;
            end else begin
              state <= S_CLEAR;
              busy  <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          state    <= S_FEED;
          in_ready <= 1'b1;
          beat_cnt <= '0;
        end
        S_FEED: begin
          if (in_valid) begin
            if (beat_cnt == BEAT_LAST) begin
              state     <= S_DRAIN;
              in_ready  <= 1'b0;
              drain_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (all_done) begin
            state <= S_CAPTURE;
          end else if (drain_cnt == DRAIN_LAST) begin
            // Lanes never finished: abandon the job without producing a result.
            state   <= S_IDLE;
            timeout <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          state     <= S_OUT;
          out_valid <= 1'b1;
        end
        S_OUT: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign en_raw      = ((state == S_FEED) && in_valid) || (state == S_DRAIN);
  assign reset_acc   = (state == S_CLEAR);
  assign capture     = (state == S_CAPTURE);
  assign zero_inputs = (state == S_DRAIN);
  assign state_dbg   = state;

endmodule

// File: rtl/multi_matmul_seq_wrapper.sv
// Shared-north multi-matmul wrapper with a start/done sequencer, per-lane enable masking
// and a registered result bank returned over a valid/ready handshake.
module multi_matmul_seq_wrapper
  import mm_seq_pkg::*;
#(
  parameter int WIDTH_A         = 16,
  parameter int FRAC_WIDTH_A    = 8,
  parameter int WIDTH_B         = 16,
  parameter int FRAC_WIDTH_B    = 8,
  parameter int WIDTH_OUT       = 16,
  parameter int FRAC_WIDTH_OUT  = 8,
  parameter int BLOCK_SIZE      = 2,
  parameter int CHUNK_SIZE      = 4,
  parameter int NUM_CORES_A     = 4,
  parameter int NUM_CORES_B     = 1,
  parameter int TOTAL_MODULES   = 2,
  parameter int INNER_DIMENSION = 64,
  parameter int TOTAL_INPUT_W   = 2,
  parameter int DRAIN_MAX       = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [TOTAL_INPUT_W-1:0] lane_mask,
  input  logic in_valid,
  output logic in_ready,
  input  logic [TOTAL_INPUT_W*WIDTH_A*CHUNK_SIZE*NUM_CORES_A-1:0] input_w,
  input  logic [WIDTH_B*CHUNK_SIZE*NUM_CORES_B*TOTAL_MODULES-1:0] input_n,
  output logic out_valid,
  input  logic out_ready,
  output logic [TOTAL_INPUT_W*WIDTH_OUT*CHUNK_SIZE*NUM_CORES_A*NUM_CORES_B*TOTAL_MODULES-1:0] out_data,
  output logic [TOTAL_INPUT_W-1:0] out_lane_mask,
  output logic busy,
  output logic done,
  output logic timeout
);

  localparam int LW = WIDTH_A * CHUNK_SIZE * NUM_CORES_A;
  localparam int NW = WIDTH_B * CHUNK_SIZE * NUM_CORES_B * TOTAL_MODULES;
  localparam int OW = WIDTH_OUT * CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B * TOTAL_MODULES;
  localparam int K_BEATS = k_beats(INNER_DIMENSION, BLOCK_SIZE);

  logic [TOTAL_INPUT_W-1:0] mask_q;
  logic [TOTAL_INPUT_W-1:0] lane_done;
  logic [OW-1:0]            lane_out [TOTAL_INPUT_W];
  logic [NW-1:0]            lane_n;
  logic                     en_raw;
  logic                     reset_acc;
  logic                     capture;
  logic                     zero_inputs;
  logic                     all_done;
  state_t                   state_dbg;

  // Unmasked lanes never run, so they must not hold the drain open.
  assign all_done = &(lane_done | ~mask_q);
  assign lane_n   = zero_inputs ? '0 : input_n;

  mm_seq_fsm #(
    .K_BEATS  (K_BEATS),
    .DRAIN_MAX(DRAIN_MAX),
    .LANES    (TOTAL_INPUT_W)
  ) u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .lane_mask  (lane_mask),
    .in_valid   (in_valid),
    .all_done   (all_done),
    .out_ready  (out_ready),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .mask_q     (mask_q),
    .en_raw     (en_raw),
    .reset_acc  (reset_acc),
    .capture    (capture),
    .zero_inputs(zero_inputs),
    .state_dbg  (state_dbg)
  );

  for (genvar i = 0; i < TOTAL_INPUT_W; i++) begin : g_lane
    logic          lane_en;
    logic [LW-1:0] lane_w;

    assign lane_en = en_raw & mask_q[i];
    assign lane_w  = zero_inputs ? '0 : input_w[i*LW +: LW];

    multi_matmul #(
      .WIDTH_A        (WIDTH_A),
      .FRAC_WIDTH_A   (FRAC_WIDTH_A),
      .WIDTH_B        (WIDTH_B),
      .FRAC_WIDTH_B   (FRAC_WIDTH_B),
      .WIDTH_OUT      (WIDTH_OUT),
      .FRAC_WIDTH_OUT (FRAC_WIDTH_OUT),
      .BLOCK_SIZE     (BLOCK_SIZE),
      .CHUNK_SIZE     (CHUNK_SIZE),
      .NUM_CORES_A    (NUM_CORES_A),
      .NUM_CORES_B    (NUM_CORES_B),
      .TOTAL_MODULES  (TOTAL_MODULES),
      .INNER_DIMENSION(INNER_DIMENSION)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .reset_acc(reset_acc),
      .en       (lane_en),
      .input_w  (lane_w),
      .input_n  (lane_n),
      .out      (lane_out[i]),
      .acc_done (lane_done[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data      <= '0;
      out_lane_mask <= '0;
    end else if (capture) begin
      for (int i = 0; i < TOTAL_INPUT_W; i++)
        out_data[i*OW +: OW] <= mask_q[i] ? lane_out[i] : '0;
      out_lane_mask <= mask_q;
    end
  end

  a_out_valid_in_out: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> (state_dbg == S_OUT));

endmodule

// File: tb/tb_multi_matmul_seq_wrapper.sv
// Randomized bench for multi_matmul_seq_wrapper against a direct sum-of-products reference.
module tb_multi_matmul_seq_wrapper;

  localparam int L  = 2;
  localparam int LW = 16 * 4 * 4;
  localparam int NW = 16 * 4 * 1 * 2;
  localparam int OW = 16 * 4 * 4 * 1 * 2;
  localparam int K  = 32;
  localparam int TK = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main instance (defaults)
  logic          start, in_valid, out_ready;
  logic [L-1:0]  lane_mask;
  logic [L*LW-1:0] input_w;
  logic [NW-1:0] input_n;
  logic          in_ready, out_valid, busy, done, timeout;
  logic [L*OW-1:0] out_data;
  logic [L-1:0]  out_lane_mask;

  // timeout instance (short job, drain limit below lane latency)
  logic          t_start, t_in_valid, t_out_ready;
  logic [L-1:0]  t_lane_mask;
  logic [L*LW-1:0] t_input_w;
  logic [NW-1:0] t_input_n;
  logic          t_in_ready, t_out_valid, t_busy, t_done, t_timeout;
  logic [L*OW-1:0] t_out_data;
  logic [L-1:0]  t_out_lane_mask;

  multi_matmul_seq_wrapper dut (
    .clk(clk), .rst_n(rst_n), .start(start), .lane_mask(lane_mask),
    .in_valid(in_valid), .in_ready(in_ready), .input_w(input_w), .input_n(input_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane_mask(out_lane_mask), .busy(busy), .done(done), .timeout(timeout)
  );

  multi_matmul_seq_wrapper #(.INNER_DIMENSION(8), .DRAIN_MAX(1)) dut_t (
    .clk(clk), .rst_n(rst_n), .start(t_start), .lane_mask(t_lane_mask),
    .in_valid(t_in_valid), .in_ready(t_in_ready), .input_w(t_input_w), .input_n(t_input_n),
    .out_valid(t_out_valid), .out_ready(t_out_ready), .out_data(t_out_data),
    .out_lane_mask(t_out_lane_mask), .busy(t_busy), .done(t_done), .timeout(t_timeout)
  );

  // scoreboard
  int n_total = 0;
  int n_bad   = 0;
  logic [L*LW-1:0] beat_w[$];
  logic [NW-1:0]   beat_n[$];
  logic [OW-1:0]   exp_q[$];

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: every element is the plain sum over accepted beats of w*n, scaled by 2^-8.
  function automatic logic [OW-1:0] model_lane(input int lane);
    logic [OW-1:0] r;
    logic [15:0]   wv;
    logic [15:0]   nv;
    longint        s;
    logic [63:0]   sh;
    r = '0;
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 4; a++)
        for (int k = 0; k < 4; k++) begin
          s = 0;
          for (int b = 0; b < beat_w.size(); b++) begin
            wv = beat_w[b][lane*LW + (a*4 + k)*16 +: 16];
            nv = beat_n[b][(m*4 + k)*16 +: 16];
            s += longint'($signed(wv)) * longint'($signed(nv));
          end
          sh = s >>> 8;
          r[((m*4 + a)*4 + k)*16 +: 16] = sh[15:0];
        end
    return r;
  endfunction

  // driver tasks
  task automatic rand_data();
    for (int i = 0; i < L*LW/32; i++) input_w[i*32 +: 32] = $urandom();
    for (int i = 0; i < NW/32; i++)   input_n[i*32 +: 32] = $urandom();
  endtask

  task automatic run_job(input logic [L-1:0] mask, input int stall_pct, input int hold,
                         input bit pulse_start);
    logic [OW-1:0] e0, e1;
    int got, guard;
    bit v, rdy;
    beat_w.delete();
    beat_n.delete();
    start = 1'b1;
    lane_mask = mask;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("in_ready_in_clear", in_ready, 0);
    @(posedge clk); #1;
    check("in_ready_in_feed", in_ready, 1);
    got = 0;
    guard = 0;
    while (got < K && guard < 2000) begin
      v = ($urandom_range(99) >= stall_pct);
      in_valid = v;
      rand_data();
      if (pulse_start && got == 5) begin
        start = 1'b1;
        lane_mask = ~mask;
      end else begin
        start = 1'b0;
      end
      rdy = in_ready;
      @(posedge clk); #1;
      if (v && rdy) begin
        beat_w.push_back(input_w);
        beat_n.push_back(input_n);
        got++;
      end
      guard++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    check("beats_accepted", got, K);
    check("in_ready_after_feed", in_ready, 0);
    exp_q.push_back(mask[0] ? model_lane(0) : '0);
    exp_q.push_back(mask[1] ? model_lane(1) : '0);
    guard = 0;
    while (!out_valid && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    check("out_valid_rise", out_valid, 1);
    e0 = exp_q.pop_front();
    e1 = exp_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start = h[0];
      lane_mask = ~mask;
      check("out_valid_held", out_valid, 1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("lane0_data", out_data[OW-1:0], e0);
    check("lane1_data", out_data[2*OW-1:OW], e1);
    check("out_lane_mask", out_lane_mask, mask);
    check("done_low_in_out", done, 0);
    check("timeout_clear", timeout, 0);
    out_ready = 1'b1;
    start = 1'b1;
    lane_mask = mask;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start = 1'b0;
    check("done_pulse", done, 1);
    check("out_valid_fall", out_valid, 0);
    check("busy_fall", busy, 0);
    @(posedge clk); #1;
    check("done_single", done, 0);
    check("start_ignored_on_exit", busy, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_data0"}, out_data[OW-1:0], '0);
    check({tag, "_data1"}, out_data[2*OW-1:OW], '0);
    check({tag, "_mask"}, out_lane_mask, 0);
  endtask

  initial begin
    int got, guard;
    bit rdy, seen_ov;
    rst_n = 1'b0;
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; lane_mask = '0;
    input_w = '0; input_n = '0;
    t_start = 1'b0; t_in_valid = 1'b0; t_out_ready = 1'b0; t_lane_mask = '0;
    t_input_w = '0; t_input_n = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    check("t_reset_busy", t_busy, 0);
    rst_n = 1'b1;

    run_job(2'b11, 0, 0, 0);
    run_job(2'b11, 50, 0, 0);
    run_job(2'b01, 30, 0, 1);
    run_job(2'b10, 0, 0, 0);

    // empty mask: immediate done, never busy
    lane_mask = 2'b00;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("mask0_done", done, 1);
    check("mask0_busy", busy, 0);
    @(posedge clk); #1;
    check("mask0_done_clear", done, 0);
    check("mask0_busy_idle", busy, 0);

    run_job(2'b11, 20, 20, 0);

    // reset in the middle of FEED
    lane_mask = 2'b11;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      rand_data();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_values("midreset");
    rst_n = 1'b1;
    run_job(2'b11, 10, 3, 0);

    // drain limit expires before the lanes report done
    t_lane_mask = 2'b11;
    t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
    got = 0;
    guard = 0;
    while (got < TK && guard < 50) begin
      t_in_valid = 1'b1;
      t_input_w = {$urandom(), $urandom()};
      rdy = t_in_ready;
      @(posedge clk); #1;
      if (rdy) got++;
      guard++;
    end
    t_in_valid = 1'b0;
    check("t_beats", got, TK);
    seen_ov = 1'b0;
    guard = 0;
    while (!t_done && guard < 40) begin
      if (t_out_valid) seen_ov = 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    check("t_done_latency", guard, 1);
    check("t_done", t_done, 1);
    check("t_timeout_set", t_timeout, 1);
    check("t_busy_low", t_busy, 0);
    check("t_no_out_valid", seen_ov | t_out_valid, 0);
    @(posedge clk); #1;
    check("t_timeout_sticky", t_timeout, 1);
    check("t_done_single", t_done, 0);
    t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
    check("t_timeout_cleared", t_timeout, 0);
    check("t_busy_restart", t_busy, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_matmul_seq_wrapper.md
# multi_matmul_seq_wrapper

Sequenced successor to the shared-north multi-matmul wrapper. It holds TOTAL_INPUT_W `multi_matmul` lanes that all receive the same north operand, each with its own west operand. A start/done FSM drives `reset_acc` and `en`, accepts operand beats over a valid/ready handshake, masks off unused lanes, and returns registered results over a valid/ready output handshake. It sits between the Q/K/V operand streamers and the attention score/softmax stage.

## Interface
- WIDTH_A, 16, west operand element width; FRAC_WIDTH_A, 8, its fraction bits
- WIDTH_B, 16, north operand element width; FRAC_WIDTH_B, 8, its fraction bits
- WIDTH_OUT, 16, result element width; FRAC_WIDTH_OUT, 8, its fraction bits
- BLOCK_SIZE, 2; CHUNK_SIZE, 4; NUM_CORES_A, 4; NUM_CORES_B, 1; TOTAL_MODULES, 2: passed unchanged to every lane
- INNER_DIMENSION, 64, reduction length; K_BEATS = INNER_DIMENSION/BLOCK_SIZE input beats per job
- TOTAL_INPUT_W, 2, physical lane count (≥1)
- DRAIN_MAX, 256, cycle limit for the drain phase before a timeout is declared
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low
- start  in  1  job request pulse; sampled only in IDLE
- lane_mask  in  TOTAL_INPUT_W  enabled lanes; latched on start
- in_valid  in  1  operand beat valid
- in_ready  out  1  beat accepted when in_valid&&in_ready
- input_w  in  WIDTH_A*CHUNK_SIZE*NUM_CORES_A × [TOTAL_INPUT_W]  per-lane west operand
- input_n  in  WIDTH_B*CHUNK_SIZE*NUM_CORES_B*TOTAL_MODULES  shared north operand
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid&&out_ready
- out_data  out  WIDTH_OUT*CHUNK_SIZE*NUM_CORES_A*NUM_CORES_B*TOTAL_MODULES × [TOTAL_INPUT_W]  registered per-lane results
- out_lane_mask  out  TOTAL_INPUT_W  copy of the latched mask that goes with out_data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a job completes or aborts
- timeout  out  1  sticky error flag; cleared by the next accepted start

## Operation
- **IDLE.** in_ready=0. On start=1:
  - latch lane_mask into mask_q and clear timeout;
  - if lane_mask==0, pulse done and stay in IDLE;
  - otherwise go to CLEAR.
- **CLEAR.** Assert reset_acc to all lanes for 1 cycle with en=0, then go to FEED.
- **FEED.** in_ready=1.
  - Each accepted beat asserts lane en for that cycle on lanes with mask_q[i]=1; masked-off lanes always see en=0.
  - While in_valid=0, en=0, so the lanes stall.
  - beat_cnt counts 0..K_BEATS-1. On the accepted beat with beat_cnt==K_BEATS-1, go to DRAIN.
- **DRAIN.** in_ready=0. en=1 on masked lanes, with input_w and input_n forced to zero.
  - Exit when every masked lane reports acc_done (AND over masked lanes of acc_done; unmasked lanes count as done) → CAPTURE.
  - If drain_cnt reaches DRAIN_MAX → set timeout, pulse done, go to IDLE with no output.
- **CAPTURE.** In 1 cycle, register each masked lane's result into out_data[i]; unmasked lanes are written with 0. out_lane_mask=mask_q. Go to OUT.
- **OUT.** out_valid=1; out_data is held stable while out_ready=0. On out_ready=1: pulse done, drop out_valid, go to IDLE.
- **Arithmetic.** No arithmetic in this block; lanes produce WIDTH_OUT/FRAC_WIDTH_OUT fixed-point values and results pass through bit-exact.

## Timing
- **Reset values.** in_ready, out_valid, busy, done and timeout are 0; out_data and out_lane_mask are all zero; FSM is in IDLE; beat_cnt and drain_cnt are 0. rst_n also feeds every lane.
- **Reset mid-job.** rst_n=0 in any state returns to IDLE on the next edge. No done pulse; the partial job is discarded.
- **Start latency.** start accepted at cycle t → reset_acc at t+1 → in_ready=1 from t+2.
- **FEED minimum.** K_BEATS cycles at full throughput. There is no skid buffer: in_ready is a registered function of state only.
- **Result latency.** out_valid rises 1 cycle after the drain exit condition.
- **Completion.** done is registered and asserted in the same cycle that out_valid falls. start in that cycle is ignored, because the FSM is still leaving OUT.
- **start while busy** is ignored and mask_q is unchanged.
- **Back-pressure.** out_ready held low indefinitely stalls in OUT; a new job cannot begin until the result is taken.

## Structure
- **Package mm_seq_pkg:**
  - state enum {IDLE, CLEAR, FEED, DRAIN, CAPTURE, OUT};
  - function k_beats(INNER_DIMENSION, BLOCK_SIZE);
  - counter width helper based on $clog2.
- **Sub-module mm_seq_fsm:** owns the state, beat and drain counters, and the handshake outputs. It emits en_raw, reset_acc, capture and zero_inputs.
- **Top level:** generate-loop of `multi_matmul` lanes with per-lane en gating, plus the output register bank.

## Test plan
- **Full run.** Defaults, mask=2'b11, 32 beats with identity-like operands → out_valid with both lanes matching the golden model; done pulses once; busy falls with done.
- **Input stalls.** in_valid toggled 50% random → same results as the unstalled run; beat_cnt reaches exactly 32; lanes see no extra en during FEED.
- **Partial mask.** mask=2'b01 → out_data[1]==0, out_lane_mask=2'b01, lane 1 en stays 0 for the whole job. mask=0 → done 1 cycle after start and busy stays 0.
- **Output back-pressure.** out_ready low for 20 cycles → out_data stable, out_valid held; start pulses during the hold are ignored.
- **Timeout.** acc_done forced low with DRAIN_MAX=16 → timeout=1 and done 16 cycles into DRAIN, out_valid never rises; the next start clears timeout.
- **Reset mid-FEED.** rst_n low at beat 10 → all outputs return to their reset values and the FSM is in IDLE; a following full job produces correct results.
